// File: rtl/conbus_pkg.sv
// Shared constants and types for the 4-master conbus: master count, index type,
// default widths and the outstanding-read pipeline slot.
package conbus_pkg;

    localparam int unsigned NMASTERS   = 4;
    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 16;

    typedef logic [1:0] midx_t;

    typedef struct packed {
        logic  valid;
        midx_t idx;
    } rd_slot_t;

    function automatic midx_t onehot_to_idx(input logic [NMASTERS-1:0] oh);
        midx_t idx;
        idx = '0;
        for (int unsigned i = 0; i < NMASTERS; i++) begin
            if (oh[i]) idx = midx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/conbus4x1_if.sv
// Request/lock/grant bundle between the masters and the round-robin arbiter.
interface conbus4x1_if;
    import conbus_pkg::*;

    logic [NMASTERS-1:0] req;
    logic [NMASTERS-1:0] lock;
    logic [NMASTERS-1:0] gnt;

    modport master (output req, output lock, input gnt);
    modport slave  (input req, input lock, output gnt);

endinterface

// File: rtl/conbus_rr_arbiter.sv
// Round-robin arbiter with last-granted pointer; bus ownership lock is only
// honoured when CONBUS4X1_LOCK_EN is defined.
module conbus_rr_arbiter
    import conbus_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    conbus4x1_if.slave bus
);

    midx_t               ptr_q, ptr_d;
    midx_t               idx;
    logic [NMASTERS-1:0] gnt;
    logic                hold;
    logic                found;

`ifndef CONBUS4X1_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^bus.lock;
`endif

    always_comb begin
        gnt   = '0;
        hold  = 1'b0;
        found = 1'b0;
        idx   = '0;
`ifdef CONBUS4X1_LOCK_EN
        hold = bus.req[ptr_q] & bus.lock[ptr_q];
`endif
        if (rst) begin
            gnt = '0;
        end else if (hold) begin
            gnt[ptr_q] = 1'b1;
        end else begin
            // Search starts one past the last granted master and wraps.
            for (int unsigned off = 1; off <= NMASTERS; off++) begin
                idx = ptr_q + midx_t'(off);
                if (!found && bus.req[idx]) begin
                    gnt[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
        ptr_d = (|gnt) ? onehot_to_idx(gnt) : ptr_q;
    end

    assign bus.gnt = gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= midx_t'(NMASTERS - 1);
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/conbus4x1.sv
// Four-master to one-slave bus switch with registered slave side and a
// two-stage read-return pipeline. Optional bus lock: CONBUS4X1_LOCK_EN.
module conbus4x1
    import conbus_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_a,
    input  logic [DATA_W-1:0] m0_do,
    input  logic              m0_lock,
    output logic              m0_gnt,
    output logic              m0_rdv,
    output logic [DATA_W-1:0] m0_di,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_a,
    input  logic [DATA_W-1:0] m1_do,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rdv,
    output logic [DATA_W-1:0] m1_di,

    input  logic              m2_req,
    input  logic              m2_we,
    input  logic [ADDR_W-1:0] m2_a,
    input  logic [DATA_W-1:0] m2_do,
    input  logic              m2_lock,
    output logic              m2_gnt,
    output logic              m2_rdv,
    output logic [DATA_W-1:0] m2_di,

    input  logic              m3_req,
    input  logic              m3_we,
    input  logic [ADDR_W-1:0] m3_a,
    input  logic [DATA_W-1:0] m3_do,
    input  logic              m3_lock,
    output logic              m3_gnt,
    output logic              m3_rdv,
    output logic [DATA_W-1:0] m3_di,

    output logic [ADDR_W-1:0] s_a,
    output logic              s_we,
    output logic [DATA_W-1:0] s_do,
    input  logic [DATA_W-1:0] s_di
);

    conbus4x1_if arb_bus ();

    logic [NMASTERS-1:0] m_we;
    logic [ADDR_W-1:0]   m_a  [NMASTERS];
    logic [DATA_W-1:0]   m_do [NMASTERS];
    logic [NMASTERS-1:0] rdv;

    midx_t               gnt_idx;
    logic                any_gnt;
    logic [ADDR_W-1:0]   s_a_q, s_a_d;
    logic                s_we_q, s_we_d;
    logic [DATA_W-1:0]   s_do_q, s_do_d;
    rd_slot_t            rd1_q, rd1_d;
    rd_slot_t            rd2_q, rd2_d;

    assign arb_bus.req  = {m3_req, m2_req, m1_req, m0_req};
    assign arb_bus.lock = {m3_lock, m2_lock, m1_lock, m0_lock};
    assign m_we         = {m3_we, m2_we, m1_we, m0_we};
    assign m_a[0]  = m0_a;
    assign m_a[1]  = m1_a;
    assign m_a[2]  = m2_a;
    assign m_a[3]  = m3_a;
    assign m_do[0] = m0_do;
    assign m_do[1] = m1_do;
    assign m_do[2] = m2_do;
    assign m_do[3] = m3_do;

    conbus_rr_arbiter u_arb (
        .clk (sys_clk),
        .rst (sys_rst),
        .bus (arb_bus)
    );

    always_comb begin
        gnt_idx = onehot_to_idx(arb_bus.gnt);
        any_gnt = |arb_bus.gnt;
        s_a_d   = s_a_q;
        s_do_d  = s_do_q;
        s_we_d  = 1'b0;
        rd1_d   = '0;
        if (any_gnt) begin
            s_a_d       = m_a[gnt_idx];
            s_do_d      = m_do[gnt_idx];
            s_we_d      = m_we[gnt_idx];
            rd1_d.valid = ~m_we[gnt_idx];
            rd1_d.idx   = gnt_idx;
        end
        // Slave returns data one cycle after s_a, so rdv is two cycles after grant.
        rd2_d = rd1_q;
        for (int unsigned i = 0; i < NMASTERS; i++) begin
            rdv[i] = rd2_q.valid && (rd2_q.idx == midx_t'(i));
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s_a_q  <= '0;
            s_we_q <= 1'b0;
            s_do_q <= '0;
            rd1_q  <= '0;
            rd2_q  <= '0;
        end else begin
            s_a_q  <= s_a_d;
            s_we_q <= s_we_d;
            s_do_q <= s_do_d;
            rd1_q  <= rd1_d;
            rd2_q  <= rd2_d;
        end
    end

    assign s_a  = s_a_q;
    assign s_we = s_we_q;
    assign s_do = s_do_q;

    assign m0_gnt = arb_bus.gnt[0];
    assign m1_gnt = arb_bus.gnt[1];
    assign m2_gnt = arb_bus.gnt[2];
    assign m3_gnt = arb_bus.gnt[3];
    assign m0_rdv = rdv[0];
    assign m1_rdv = rdv[1];
    assign m2_rdv = rdv[2];
    assign m3_rdv = rdv[3];
    assign m0_di  = s_di;
    assign m1_di  = s_di;
    assign m2_di  = s_di;
    assign m3_di  = s_di;

endmodule

// File: doc/conbus4x1.md
CONBUS4X1 -- requirements
Module: conbus4x1

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, master and slave address width.
REQ-002 SHALL have parameter DATA_W, default 16, data width.
REQ-003 SHALL have port sys_clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port sys_rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have, for N in 0..3, port mN_req  in  1  master N requests one bus access.
REQ-006 SHALL have, for N in 0..3, port mN_we  in  1  write when 1, read when 0.
REQ-007 SHALL have, for N in 0..3, port mN_a  in  ADDR_W  access address.
REQ-008 SHALL have, for N in 0..3, port mN_do  in  DATA_W  write data.
REQ-009 SHALL have, for N in 0..3, port mN_lock  in  1  hold ownership (used only with the macro in REQ-027).
REQ-010 SHALL have, for N in 0..3, port mN_gnt  out  1  access accepted this cycle.
REQ-011 SHALL have, for N in 0..3, port mN_rdv  out  1  read data valid on mN_di.
REQ-012 SHALL have, for N in 0..3, port mN_di  out  DATA_W  read data, combinational copy of s_di.
REQ-013 SHALL have port s_a  out  ADDR_W  registered slave address.
REQ-014 SHALL have port s_we  out  1  registered slave write enable.
REQ-015 SHALL have port s_do  out  DATA_W  registered slave write data.
REQ-016 SHALL have port s_di  in  DATA_W  slave read data, valid one cycle after s_a (synchronous-read slave, conbus convention).

Function
REQ-017 SHALL grant at most one master per cycle; mN_gnt is combinational from mN_req and the round-robin pointer.
REQ-018 SHALL arbitrate round-robin: search starts at (last_granted+1) mod 4; highest priority goes to the master after the last one granted.
REQ-019 SHALL update last_granted on every cycle with a grant; with no requests, pointer holds.
REQ-020 SHALL register the granted master's a/we/do into s_a/s_we/s_do at the granting edge (cycle N grant -> slave sees access in N+1).
REQ-021 SHALL drive s_we=0 in any cycle following a cycle with no grant; s_a/s_do hold their last value.
REQ-022 SHALL pulse mN_rdv for one cycle in N+2 for a read granted in cycle N; write grants produce no rdv.
REQ-023 SHALL track outstanding reads with a 2-stage pipeline of {valid, master index}; back-to-back reads from any masters SHALL return in grant order, one per cycle.
REQ-024 SHALL keep a master that holds mN_req without gnt stalled with no side effects; masters hold a/we/do until gnt.
REQ-025 SHALL treat mN_req dropped before gnt as withdrawn; no access issued.

Reset
REQ-026 SHALL, on sys_rst asserted (asynchronous), set the pointer to 3 (master 0 wins first), s_a=0, s_we=0, s_do=0, all mN_rdv=0, and clear the read pipeline; mN_gnt=0 while sys_rst=1; reads in flight at reset are discarded, no rdv after release.

Configuration
REQ-027 SHALL, with CONBUS4X1_LOCK_EN defined, keep ownership with the last granted master while it asserts mN_req and mN_lock, overriding round-robin; ownership is released on the first cycle either is low.
REQ-028 SHALL, without CONBUS4X1_LOCK_EN, ignore all mN_lock inputs and apply pure round-robin.

Structure
REQ-029 SHALL take NMASTERS=4, master index type (2 bits) and default widths from the shared package conbus_pkg.
REQ-030 SHALL implement grant selection and the pointer in sub-module conbus_rr_arbiter (4 req in, one-hot gnt out, lock input).

Verification
REQ-031 SHALL check reset: hold sys_rst 2 cycles with m0_req=1 -> m0_gnt=0, s_we=0, s_a=0; first cycle after release -> m0_gnt=1.
REQ-032 SHALL check a single read: m2_req=1, m2_a=16'h8004, s_di=16'h2222 -> m2_gnt in cycle N, s_a=16'h8004 in N+1, m2_rdv=1 and m2_di=16'h2222 in N+2.
REQ-033 SHALL check contention: all four requesting continuously from reset -> grants m0,m1,m2,m3,m0 in consecutive cycles.
REQ-034 SHALL check a write: m1_req=1, m1_we=1, m1_a=16'h4000, m1_do=16'hBEEF -> s_we=1, s_a=16'h4000, s_do=16'hBEEF for exactly one cycle; no m1_rdv.
REQ-035 SHALL check lock: with CONBUS4X1_LOCK_EN, m3 granted with m3_lock=1 and m0 requesting -> m3 granted 3 consecutive cycles; m0 granted in the cycle after m3_lock=0.
REQ-036 SHALL check reset mid-read: sys_rst asserted in N+1 of an m0 read -> no m0_rdv in any later cycle.
